state_mat_seq: RTL and testbench

Sequencer that owns the single access port of the `data_mat` AES state matrix. It loads a 128-bit block as four 32-bit columns over a valid/ready stream, then performs ShiftRows in place on the matrix `SHIFT_PASSES` times using row reads and row writes. It then unloads the four columns over a second valid/ready stream. It sits between the block input/key-mix stage and the MixColumns stage of the AES-128 datapath and is the only master of `data_mat`.

---
 rtl/state_mat_seq_if.sv | 26 ++
 rtl/state_mat_seq.sv | 161 ++++++++++++++++
 tb/tb_state_mat_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/state_mat_seq_if.sv
// Access bus of the data_mat AES state matrix.
//   mat_col_in       : write data (column or row word)
//   mat_idx          : row or column index
//   mat_row_col      : 0 = row access, 1 = column access
//   mat_read_write   : 0 = read, 1 = write
//   mat_write_enable : write strobe
//   mat_out          : read data, combinational from the current address
// master = sequencer side, slave = matrix side.
interface state_mat_seq_if;
   logic [31:0] mat_col_in;
   logic [1:0]  mat_idx;
   logic        mat_row_col;
   logic        mat_read_write;
   logic        mat_write_enable;
   logic [31:0] mat_out;

   modport master (
      output mat_col_in, mat_idx, mat_row_col, mat_read_write, mat_write_enable,
      input  mat_out
   );

   modport slave (
      input  mat_col_in, mat_idx, mat_row_col, mat_read_write, mat_write_enable,
      output mat_out
   );
endinterface

// File: rtl/state_mat_seq.sv
// Sole master of the data_mat state matrix: loads four 32-bit columns from a
// valid/ready stream, applies ShiftRows SHIFT_PASSES times in place (row read
// then rotated row write for rows 1..3), then unloads the four columns on a
// second valid/ready stream.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data/valid/ready : column load stream, row 0 in [31:24]
//   out_data/valid/ready: column unload stream, same byte order
//   busy                : high while shifting or unloading
//   done                : one-cycle pulse after the last unload beat
//   mat                 : data_mat access bus (master side)
module state_mat_seq #(
   parameter int SHIFT_PASSES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [31:0]        out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               done,
   state_mat_seq_if.master    mat
);

   typedef enum logic [1:0] {LOAD, SHIFT_RD, SHIFT_WR, UNLOAD} state_e;

   localparam bit         DO_SHIFT  = (SHIFT_PASSES > 0);
   localparam logic [1:0] LAST_PASS = (SHIFT_PASSES > 0) ? 2'(SHIFT_PASSES - 1) : 2'd0;

   state_e      state_q, state_d;
   logic [1:0]  idx_cnt_q, idx_cnt_d;
   logic [1:0]  row_cnt_q, row_cnt_d;
   logic [1:0]  pass_cnt_q, pass_cnt_d;
   logic [31:0] row_buf_q, row_buf_d;
   logic        done_q, done_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= LOAD;
         idx_cnt_q  <= '0;
         row_cnt_q  <= '0;
         pass_cnt_q <= '0;
         row_buf_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_cnt_q  <= idx_cnt_d;
         row_cnt_q  <= row_cnt_d;
         pass_cnt_q <= pass_cnt_d;
         row_buf_q  <= row_buf_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d              = state_q;
      idx_cnt_d            = idx_cnt_q;
      row_cnt_d            = row_cnt_q;
      pass_cnt_d           = pass_cnt_q;
      row_buf_d            = row_buf_q;
      done_d               = 1'b0;
      in_ready             = 1'b0;
      out_valid            = 1'b0;
      out_data             = '0;
      busy                 = 1'b0;
      mat.mat_col_in       = '0;
      mat.mat_idx          = '0;
      mat.mat_row_col      = 1'b0;
      mat.mat_read_write   = 1'b0;
      mat.mat_write_enable = 1'b0;

      case (state_q)
         LOAD: begin
            in_ready             = 1'b1;
            mat.mat_row_col      = 1'b1;
            mat.mat_read_write   = 1'b1;
            mat.mat_idx          = idx_cnt_q;
            mat.mat_col_in       = in_data;
            mat.mat_write_enable = in_valid;
            if (in_valid) begin
               if (idx_cnt_q == 2'd3) begin
                  idx_cnt_d = '0;
                  if (DO_SHIFT) begin
                     state_d    = SHIFT_RD;
                     row_cnt_d  = 2'd1;
                     pass_cnt_d = '0;
                  end else begin
                     state_d = UNLOAD;
                  end
               end else begin
                  idx_cnt_d = idx_cnt_q + 2'd1;
               end
            end
         end

         SHIFT_RD: begin
            busy        = 1'b1;
            mat.mat_idx = row_cnt_q;
            row_buf_d   = mat.mat_out;
            state_d     = SHIFT_WR;
         end

         SHIFT_WR: begin
            busy                 = 1'b1;
            mat.mat_read_write   = 1'b1;
            mat.mat_idx          = row_cnt_q;
            mat.mat_write_enable = 1'b1;
            // Row r rotates left by r bytes: column c takes old column c+r.
            case (row_cnt_q)
               2'd1:    mat.mat_col_in = {row_buf_q[23:0], row_buf_q[31:24]};
               2'd2:    mat.mat_col_in = {row_buf_q[15:0], row_buf_q[31:16]};
               2'd3:    mat.mat_col_in = {row_buf_q[7:0],  row_buf_q[31:8]};
               default: mat.mat_col_in = row_buf_q;
            endcase
            if (row_cnt_q != 2'd3) begin
               row_cnt_d = row_cnt_q + 2'd1;
               state_d   = SHIFT_RD;
            end else if (pass_cnt_q < LAST_PASS) begin
               pass_cnt_d = pass_cnt_q + 2'd1;
               row_cnt_d  = 2'd1;
               state_d    = SHIFT_RD;
            end else begin
               state_d = UNLOAD;
            end
         end

         UNLOAD: begin
            busy            = 1'b1;
            mat.mat_row_col = 1'b1;
            mat.mat_idx     = idx_cnt_q;
            out_data        = mat.mat_out;
            out_valid       = 1'b1;
            if (out_ready) begin
               if (idx_cnt_q == 2'd3) begin
                  idx_cnt_d = '0;
                  state_d   = LOAD;
                  done_d    = 1'b1;
               end else begin
                  idx_cnt_d = idx_cnt_q + 2'd1;
               end
            end
         end

         default: state_d = LOAD;
      endcase

      // Reset is synchronous, so the state register still holds the old
      // state during the reset cycle; mask the visible strobes here.
      if (!rst_n) begin
         in_ready             = 1'b0;
         out_valid            = 1'b0;
         busy                 = 1'b0;
         mat.mat_write_enable = 1'b0;
      end
   end

   assign done = done_q & rst_n;

endmodule

// File: tb/tb_state_mat_seq.sv
module tb_state_mat_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]        rst_n, in_valid, in_ready, out_valid, out_ready, busy, done, mwe;
   logic [2:0][31:0]  in_data, out_data;

   int cyc = 0;
   int done_cnt [3] = '{0, 0, 0};
   int n_cmp = 0;
   int n_err = 0;

   // Tables: 0 ramp, 1 ramp after 1 pass, 2 ramp after 2 passes,
   // 3 block B, 4 block B after 1 pass.
   // Two passes move row r by 2r bytes: rows 0 and 2 stay, rows 1 and 3
   // take the byte from column c+2.
   logic [31:0] tab [5][4] = '{
      '{32'h00010203, 32'h10111213, 32'h20212223, 32'h30313233},
      '{32'h00112233, 32'h10213203, 32'h20310213, 32'h30011223},
      '{32'h00210223, 32'h10311233, 32'h20012203, 32'h30113213},
      '{32'h40414243, 32'h50515253, 32'h60616263, 32'h70717273},
      '{32'h40516273, 32'h50617243, 32'h60714253, 32'h70415263}
   };

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 3; k++)
         if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
   end

   // Instance g runs with SHIFT_PASSES = g, each with its own matrix model.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      state_mat_seq_if mif ();
      logic [7:0] m [4][4];

      state_mat_seq #(.SHIFT_PASSES(g)) dut (
         .clk       (clk),
         .rst_n     (rst_n[g]),
         .in_data   (in_data[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .out_data  (out_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .mat       (mif)
      );

      assign mwe[g] = mif.mat_write_enable;

      always_comb begin
         mif.mat_out = '0;
         for (int i = 0; i < 4; i++) begin
            if (mif.mat_row_col) mif.mat_out[31-8*i -: 8] = m[i][mif.mat_idx];
            else                 mif.mat_out[31-8*i -: 8] = m[mif.mat_idx][i];
         end
      end

      always @(posedge clk) begin
         if (mif.mat_write_enable && mif.mat_read_write) begin
            for (int i = 0; i < 4; i++) begin
               if (mif.mat_row_col) m[i][mif.mat_idx] <= mif.mat_col_in[31-8*i -: 8];
               else                 m[mif.mat_idx][i] <= mif.mat_col_in[31-8*i -: 8];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the 4th handshake.
   task automatic load_block(input int k, input int t, input int gap, output int t4);
      for (int b = 0; b < 4; b++) begin
         if (b == 1) begin
            for (int h = 0; h < gap; h++) begin
               in_valid[k] = 1'b0;
               #1 check("we_in_gap", mwe[k], 0);
               @(negedge clk);
            end
         end
         in_data[k]  = tab[t][b];
         in_valid[k] = 1'b1;
         #1;
         check("in_ready_load", in_ready[k], 1);
         check("we_on_hs", mwe[k], 1);
         t4 = cyc;
         @(negedge clk);
      end
      in_valid[k] = 1'b0;
   endtask

   // Returns at the done cycle (negedge + 1).
   task automatic unload_block(input int k, input int t, input int t4, input int lat,
                               input int hold_col, input int hold_n);
      int w;
      w = 0;
      out_ready[k] = 1'b0;
      #1;
      while (out_valid[k] !== 1'b1 && w < 40) begin
         @(negedge clk);
         #1;
         w++;
      end
      check("out_valid_rise", out_valid[k], 1);
      check("out_latency", cyc - t4, lat);
      for (int c = 0; c < 4; c++) begin
         if (c == hold_col) begin
            out_ready[k] = 1'b0;
            for (int h = 0; h < hold_n; h++) begin
               #1;
               check("hold_valid", out_valid[k], 1);
               check("hold_data", out_data[k], tab[t][c]);
               @(negedge clk);
            end
         end
         out_ready[k] = 1'b1;
         #1;
         check("out_valid", out_valid[k], 1);
         check("out_data", out_data[k], tab[t][c]);
         check("no_we_unload", mwe[k], 0);
         @(negedge clk);
      end
      out_ready[k] = 1'b0;
      #1;
      check("done_pulse", done[k], 1);
      check("in_ready_done", in_ready[k], 1);
      check("busy_done", busy[k], 0);
   endtask

   initial begin
      int t4;
      int d0;

      rst_n     = '0;
      in_valid  = '1;
      out_ready = '0;
      in_data   = '0;
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_in_ready", in_ready[k], 0);
         check("rst_we", mwe[k], 0);
         check("rst_out_valid", out_valid[k], 0);
         check("rst_busy", busy[k], 0);
         check("rst_done", done[k], 0);
      end
      in_valid = '0;
      rst_n    = '1;
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) check("post_rst_in_ready", in_ready[k], 1);

      // SHIFT_PASSES=1 ramp
      @(negedge clk);
      d0 = done_cnt[1];
      load_block(1, 0, 0, t4);
      unload_block(1, 1, t4, 7, -1, 0);
      @(negedge clk);
      #1;
      check("done_one_cycle", done[1], 0);
      check("done_count_p1", done_cnt[1] - d0, 1);

      // SHIFT_PASSES=0 passthrough
      load_block(0, 0, 0, t4);
      unload_block(0, 0, t4, 1, -1, 0);
      @(negedge clk);

      // SHIFT_PASSES=2
      load_block(2, 0, 0, t4);
      unload_block(2, 2, t4, 13, -1, 0);
      @(negedge clk);

      // Bubbles on load, backpressure on column 1
      load_block(1, 0, 2, t4);
      unload_block(1, 1, t4, 7, 1, 3);
      @(negedge clk);

      // Reset during SHIFT_WR of row 2 (cycle t4+4)
      load_block(1, 0, 0, t4);
      repeat (3) @(negedge clk);
      #1;
      check("busy_shift_wr2", busy[1], 1);
      check("we_shift_wr2", mwe[1], 1);
      rst_n[1] = 1'b0;
      #1;
      check("we_masked_rst", mwe[1], 0);
      check("busy_masked_rst", busy[1], 0);
      d0 = done_cnt[1];
      @(negedge clk);
      rst_n[1] = 1'b1;
      #1;
      check("midrst_in_ready", in_ready[1], 1);
      check("midrst_busy", busy[1], 0);
      check("midrst_out_valid", out_valid[1], 0);
      check("midrst_done", done[1], 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1 check("midrst_idle_valid", out_valid[1], 0);
      end
      check("midrst_no_done", done_cnt[1] - d0, 0);
      @(negedge clk);
      load_block(1, 0, 0, t4);
      unload_block(1, 1, t4, 7, -1, 0);
      @(negedge clk);

      // Back-to-back: block B loaded starting in the done cycle
      d0 = done_cnt[1];
      load_block(1, 0, 0, t4);
      unload_block(1, 1, t4, 7, -1, 0);
      load_block(1, 3, 0, t4);
      unload_block(1, 4, t4, 7, -1, 0);
      @(negedge clk);
      #1;
      check("b2b_done_count", done_cnt[1] - d0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
